// File: rtl/cortina_controller_pkg.sv
// Shared motor command codes and controller state encoding for the curtain
// sequencing controller.
package cortina_pkg;

    localparam logic [1:0] SUBIR = 2'b10;
    localparam logic [1:0] BAJAR = 2'b01;
    localparam logic [1:0] PARO  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        DOWN,
        DEAD,
        FAULT
    } state_e;

    // Only the two running states ever drive the motor.
    function automatic logic [1:0] accion_for(state_e s);
        case (s)
            UP:      return SUBIR;
            DOWN:    return BAJAR;
            default: return PARO;
        endcase
    endfunction

endpackage

// File: rtl/cortina_controller_if.sv
// Command/limit/status bundle between the command logic, the limit switches
// and one curtain controller.
interface cortina_controller_if;

    logic       cmd_open;
    logic       cmd_close;
    logic       cmd_stop;
    logic       lim_top;
    logic       lim_bottom;
    logic [1:0] accion;
    logic       busy;
    logic       fault;
    logic       at_top;
    logic       at_bottom;

    modport master (
        output cmd_open, cmd_close, cmd_stop, lim_top, lim_bottom,
        input  accion, busy, fault, at_top, at_bottom
    );

    modport slave (
        input  cmd_open, cmd_close, cmd_stop, lim_top, lim_bottom,
        output accion, busy, fault, at_top, at_bottom
    );

endinterface

// File: rtl/cortina_controller_limit_debounce.sv
// Two-flop synchronizer plus stability counter for one raw limit switch; the
// debounced level follows only after DEBOUNCE_CYC consecutive differing samples.
module limit_debounce #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic deb_o
);

    localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample equal to the current debounced level restarts the run.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/cortina_controller.sv
// Curtain motor sequencer: turns command pulses and debounced limits into the
// registered accion code, with reversal dead-time and a run-time watchdog.
module cortina_controller
    import cortina_pkg::*;
#(
    parameter int DEADTIME_CYC = 2_500_000,
    parameter int TIMEOUT_CYC  = 1_000_000_000,
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cortina_controller_if.slave  bus
);

    localparam int            DW        = $clog2(DEADTIME_CYC + 1);
    localparam int            RW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME_CYC - 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(TIMEOUT_CYC - 1);

    logic          at_top;
    logic          at_bottom;
    state_e        state_q;
    state_e        state_d;
    state_e        target_q;
    state_e        target_d;
    logic [DW-1:0] dead_cnt_q;
    logic [DW-1:0] dead_cnt_d;
    logic [RW-1:0] run_cnt_q;
    logic [RW-1:0] run_cnt_d;
    logic [1:0]    accion_q;
    logic          busy_q;
    logic          fault_q;
    logic          stop_req;
    logic          open_req;
    logic          close_req;
    logic          run_expired;
    logic          dead_expired;

    limit_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_top (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_i (bus.lim_top),
        .deb_o (at_top)
    );

    limit_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_bottom (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_i (bus.lim_bottom),
        .deb_o (at_bottom)
    );

    // Conflicting open+close collapses into a stop request.
    assign stop_req     = bus.cmd_stop | (bus.cmd_open & bus.cmd_close);
    assign open_req     = bus.cmd_open & ~stop_req;
    assign close_req    = bus.cmd_close & ~stop_req;
    assign run_expired  = (run_cnt_q == RUN_LAST);
    assign dead_expired = (dead_cnt_q == DEAD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            target_q   <= IDLE;
            dead_cnt_q <= '0;
            run_cnt_q  <= '0;
            accion_q   <= PARO;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            dead_cnt_q <= dead_cnt_d;
            run_cnt_q  <= run_cnt_d;
            accion_q   <= accion_for(state_d);
            busy_q     <= (state_d == UP) || (state_d == DOWN) || (state_d == DEAD);
            fault_q    <= (state_d == FAULT);
        end
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        dead_cnt_d = '0;
        run_cnt_d  = '0;

        case (state_q)
            IDLE: begin
                if (open_req && !at_top) begin
                    state_d = UP;
                end else if (close_req && !at_bottom) begin
                    state_d = DOWN;
                end
            end
            UP: begin
                if (run_expired) begin
                    state_d = FAULT;
                end else if (at_top || stop_req) begin
                    state_d = IDLE;
                end else if (close_req) begin
                    state_d  = DEAD;
                    target_d = DOWN;
                end
            end
            DOWN: begin
                if (run_expired) begin
                    state_d = FAULT;
                end else if (at_bottom || stop_req) begin
                    state_d = IDLE;
                end else if (open_req) begin
                    state_d  = DEAD;
                    target_d = UP;
                end
            end
            DEAD: begin
                if (stop_req) begin
                    state_d = IDLE;
                end else begin
                    // Retargeting keeps the dead counter running so PARO never stretches.
                    if (open_req && target_q == DOWN) begin
                        target_d = UP;
                    end else if (close_req && target_q == UP) begin
                        target_d = DOWN;
                    end
                    if (dead_expired) begin
                        if ((target_d == UP && at_top) || (target_d == DOWN && at_bottom)) begin
                            state_d = IDLE;
                        end else begin
                            state_d = target_d;
                        end
                    end else begin
                        dead_cnt_d = dead_cnt_q + 1'b1;
                    end
                end
            end
            FAULT: begin
                if (bus.cmd_stop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (at_top && at_bottom) begin
            state_d = FAULT;
        end

        if ((state_q == UP || state_q == DOWN) && state_d == state_q && !run_expired) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
    end

    assign bus.accion    = accion_q;
    assign bus.busy      = busy_q;
    assign bus.fault     = fault_q;
    assign bus.at_top    = at_top;
    assign bus.at_bottom = at_bottom;

endmodule

// File: tb/tb_cortina_controller.sv
// Scenario bench for cortina_controller: each cycle's stimulus is queued with
// the output word it must produce, then replayed and compared cycle by cycle.
module tb_cortina_controller;
    import cortina_pkg::*;

    typedef struct packed {
        logic openCmd;
        logic closeCmd;
        logic stopCmd;
        logic limTop;
        logic limBottom;
    } stim_t;

    // Expected word layout: {accion[1:0], busy, fault, at_top, at_bottom}.
    typedef struct packed {
        logic [1:0] accion;
        logic       busy;
        logic       fault;
        logic       atTop;
        logic       atBottom;
    } exp_t;

    localparam logic [4:0] NONE  = 5'b00000;
    localparam logic [4:0] OPEN  = 5'b10000;
    localparam logic [4:0] CLOSE = 5'b01000;
    localparam logic [4:0] STOP  = 5'b00100;
    localparam logic [4:0] TOP   = 5'b00010;
    localparam logic [4:0] BOT   = 5'b00001;

    logic  clk = 1'b0;
    logic  rst_n;
    int    checkCount = 0;
    int    failCount = 0;
    stim_t stimQ[$];
    exp_t  expQ[$];

    cortina_controller_if bus ();

    cortina_controller #(
        .DEADTIME_CYC (4),
        .TIMEOUT_CYC  (100),
        .DEBOUNCE_CYC (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL sim_timeout: bench still running at %0t, limit 200000", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic applyStimulus(input stim_t s);
        bus.cmd_open   = s.openCmd;
        bus.cmd_close  = s.closeCmd;
        bus.cmd_stop   = s.stopCmd;
        bus.lim_top    = s.limTop;
        bus.lim_bottom = s.limBottom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plan(input stim_t s, input exp_t e);
        stimQ.push_back(s);
        expQ.push_back(e);
    endtask

    function automatic exp_t observe();
        return {bus.accion, bus.busy, bus.fault, bus.at_top, bus.at_bottom};
    endfunction

    task automatic test_reset();
        exp_t got;
        exp_t want;
        int   step = 0;
        repeat (2) tick();
        #2;
        expQ.push_back({PARO, 4'b0000});
        got  = observe();
        want = expQ.pop_front();
        checkCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL reset_hold: got=%b want=%b", got, want);
        end
        rst_n = 1'b1;
        repeat (3) plan(NONE, {PARO, 4'b0000});
        while (expQ.size() > 0) begin
            applyStimulus(stimQ.pop_front());
            tick();
            got  = observe();
            want = expQ.pop_front();
            checkCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL reset_idle step %0d: got=%b want=%b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_open_limit();
        exp_t got;
        exp_t want;
        int   step = 0;
        plan(OPEN, {SUBIR, 4'b1000});
        repeat (4) plan(TOP, {SUBIR, 4'b1000});
        plan(TOP, {SUBIR, 4'b1010});
        plan(TOP, {PARO, 4'b0010});
        plan(OPEN | TOP, {PARO, 4'b0010});
        repeat (4) plan(NONE, {PARO, 4'b0010});
        plan(NONE, {PARO, 4'b0000});
        while (expQ.size() > 0) begin
            applyStimulus(stimQ.pop_front());
            tick();
            got  = observe();
            want = expQ.pop_front();
            checkCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL open_limit step %0d: got=%b want=%b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_reversal();
        exp_t got;
        exp_t want;
        int   step = 0;
        plan(OPEN, {SUBIR, 4'b1000});
        plan(OPEN, {SUBIR, 4'b1000});
        plan(CLOSE, {PARO, 4'b1000});
        repeat (3) plan(NONE, {PARO, 4'b1000});
        plan(NONE, {BAJAR, 4'b1000});
        plan(NONE, {BAJAR, 4'b1000});
        plan(CLOSE, {BAJAR, 4'b1000});
        plan(OPEN, {PARO, 4'b1000});
        repeat (3) plan(NONE, {PARO, 4'b1000});
        plan(NONE, {SUBIR, 4'b1000});
        plan(CLOSE, {PARO, 4'b1000});
        plan(OPEN, {PARO, 4'b1000});
        repeat (2) plan(NONE, {PARO, 4'b1000});
        plan(NONE, {SUBIR, 4'b1000});
        plan(STOP, {PARO, 4'b0000});
        while (expQ.size() > 0) begin
            applyStimulus(stimQ.pop_front());
            tick();
            got  = observe();
            want = expQ.pop_front();
            checkCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL reversal step %0d: got=%b want=%b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_watchdog();
        exp_t got;
        exp_t want;
        int   step = 0;
        plan(OPEN, {SUBIR, 4'b1000});
        repeat (99) plan(NONE, {SUBIR, 4'b1000});
        plan(NONE, {PARO, 4'b0100});
        plan(OPEN, {PARO, 4'b0100});
        plan(STOP, {PARO, 4'b0000});
        plan(NONE, {PARO, 4'b0000});
        while (expQ.size() > 0) begin
            applyStimulus(stimQ.pop_front());
            tick();
            got  = observe();
            want = expQ.pop_front();
            checkCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL watchdog step %0d: got=%b want=%b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_glitch_both();
        exp_t got;
        exp_t want;
        int   step = 0;
        plan(OPEN, {SUBIR, 4'b1000});
        repeat (2) plan(TOP, {SUBIR, 4'b1000});
        repeat (5) plan(NONE, {SUBIR, 4'b1000});
        repeat (4) plan(TOP | BOT, {SUBIR, 4'b1000});
        plan(TOP | BOT, {SUBIR, 4'b1011});
        plan(TOP | BOT, {PARO, 4'b0111});
        repeat (4) plan(NONE, {PARO, 4'b0111});
        plan(NONE, {PARO, 4'b0100});
        plan(STOP, {PARO, 4'b0000});
        while (expQ.size() > 0) begin
            applyStimulus(stimQ.pop_front());
            tick();
            got  = observe();
            want = expQ.pop_front();
            checkCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL glitch_both step %0d: got=%b want=%b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_ignored_cmds();
        exp_t got;
        exp_t want;
        int   step = 0;
        plan(OPEN | CLOSE, {PARO, 4'b0000});
        plan(NONE, {PARO, 4'b0000});
        repeat (4) plan(BOT, {PARO, 4'b0000});
        plan(BOT, {PARO, 4'b0001});
        plan(CLOSE | BOT, {PARO, 4'b0001});
        plan(BOT, {PARO, 4'b0001});
        plan(OPEN | BOT, {SUBIR, 4'b1001});
        plan(STOP | BOT, {PARO, 4'b0001});
        while (expQ.size() > 0) begin
            applyStimulus(stimQ.pop_front());
            tick();
            got  = observe();
            want = expQ.pop_front();
            checkCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL ignored_cmds step %0d: got=%b want=%b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_async_reset();
        exp_t got;
        exp_t want;
        int   step = 0;
        repeat (4) plan(TOP, {PARO, 4'b0001});
        plan(TOP, {PARO, 4'b0010});
        plan(CLOSE | TOP, {BAJAR, 4'b1010});
        plan(TOP, {BAJAR, 4'b1010});
        while (expQ.size() > 0) begin
            applyStimulus(stimQ.pop_front());
            tick();
            got  = observe();
            want = expQ.pop_front();
            checkCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL async_setup step %0d: got=%b want=%b", step, got, want);
            end
            step++;
        end

        // Reset lands mid-cycle, well away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        expQ.push_back({PARO, 4'b0000});
        got  = observe();
        want = expQ.pop_front();
        checkCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL async_reset_now: got=%b want=%b", got, want);
        end
        tick();
        expQ.push_back({PARO, 4'b0000});
        got  = observe();
        want = expQ.pop_front();
        checkCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL async_reset_held: got=%b want=%b", got, want);
        end
        rst_n = 1'b1;

        step = 0;
        repeat (4) plan(TOP, {PARO, 4'b0000});
        plan(TOP, {PARO, 4'b0010});
        plan(OPEN | TOP, {PARO, 4'b0010});
        while (expQ.size() > 0) begin
            applyStimulus(stimQ.pop_front());
            tick();
            got  = observe();
            want = expQ.pop_front();
            checkCount++;
            if (got !== want) begin
                failCount++;
                $display("[TB] FAIL async_release step %0d: got=%b want=%b", step, got, want);
            end
            step++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(NONE);
        test_reset();
        test_open_limit();
        test_reversal();
        test_watchdog();
        test_glitch_both();
        test_ignored_cmds();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule
